bsw_seq_ctrl: RTL
=================

BSW_SEQ_CTRL -- requirements
Module: bsw_seq_ctrl

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 256, symbols per sequence (power of two, 2..256).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, max WAIT cycles per job (used only with BSW_TIMEOUT_EN).
REQ-003 SHALL have ports (name  direction  width  meaning):
  clk  in  1  single clock, all logic on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  one-cycle request to run a batch; accepted only in IDLE
  num_jobs  in  4  jobs in batch, sampled at accepted start; 0 treated as 1
  busy  out  1  high from accepted start until the DONE cycle, inclusive
  done  out  1  one-cycle pulse at batch end
  mem_rd  out  1  sequence-memory read strobe
  mem_addr  out  4+log2(SEQ_LEN)  {job index, symbol index}
  mem_s  in  2  s symbol, valid the cycle after mem_rd
  mem_t  in  2  t symbol, valid the cycle after mem_rd
  core_rst  out  1  reset to the BSW core
  core_valid  out  1  i_valid to the BSW core
  core_s  out  2  data_s to core; combinational pass-through of mem_s
  core_t  out  2  data_t to core; combinational pass-through of mem_t
  core_finish  in  1  core finish
  core_max  in  12  core max score, valid with core_finish
  best_max  out  12  highest score in current batch
  best_job  out  4  job index producing best_max
  timeout  out  1  sticky: a job in this batch timed out

Function
REQ-004 SHALL implement FSM states IDLE, CRST, STREAM, DRAIN, WAIT, DONE.
REQ-005 IDLE: start=1 SHALL latch num_jobs, clear best_max/best_job/timeout and job counter, and go to CRST.
REQ-006 start while not in IDLE SHALL be ignored.
REQ-007 CRST SHALL hold core_rst=1 for exactly 2 cycles, then go to STREAM; core_rst SHALL be 0 in all other states.
REQ-008 STREAM SHALL assert mem_rd for exactly SEQ_LEN consecutive cycles, symbol index 0..SEQ_LEN-1, job field = current job index, then go to DRAIN.
REQ-009 core_valid SHALL be mem_rd delayed one cycle, so it is high for exactly SEQ_LEN consecutive cycles, ending in DRAIN.
REQ-010 DRAIN SHALL last 1 cycle, then go to WAIT.
REQ-011 WAIT: core_finish=1 SHALL sample core_max; if core_max > best_max (strict, so the earlier job wins ties), best_max/best_job SHALL update next cycle.
REQ-012 After the finish in WAIT, SHALL go to CRST with the job counter incremented if jobs remain, else to DONE.
REQ-013 DONE SHALL last 1 cycle with done=1, then go to IDLE; best_max, best_job and timeout SHALL hold until the next accepted start.
REQ-014 core_finish outside WAIT SHALL be ignored.
REQ-015 core_valid, mem_rd and core_rst SHALL be 0 in IDLE and DONE.

Reset
REQ-016 reset=1 SHALL, on the next edge in any state, enter IDLE and clear the job counter, symbol index, best_max, best_job and timeout, with busy, done, mem_rd, core_valid, core_rst=0 and mem_addr=0.
REQ-017 reset SHALL take priority over start and core_finish in the same cycle.

Configuration
REQ-018 With BSW_TIMEOUT_EN defined, a counter SHALL run in WAIT. If it reaches TIMEOUT_CYC without core_finish, the job's score SHALL be discarded, timeout SHALL set, and the FSM SHALL proceed as in REQ-012.
REQ-019 Without BSW_TIMEOUT_EN, WAIT SHALL persist until core_finish, and timeout SHALL be tied to 0.

Verification
REQ-020 num_jobs=1, core model returns max=165 ten cycles after the last core_valid -> mem_addr 0x000..0x0FF, core_valid high 256 cycles, one done pulse, best_max=165, best_job=0.
REQ-021 num_jobs=3, maxes 50,120,120 -> job field 0,1,2, core_rst 2 cycles before each job, best_max=120, best_job=1.
REQ-022 num_jobs=0 with start pulsed again mid-STREAM -> exactly one job runs, second start ignored, one done pulse.
REQ-023 reset at symbol index 100 of STREAM -> next cycle busy=0, mem_rd=0, core_valid=0; new start restarts at mem_addr 0.
REQ-024 core_finish pulsed during STREAM and DRAIN -> no score captured, stream continues unaltered.
REQ-025 BSW_TIMEOUT_EN, TIMEOUT_CYC=16, core never finishes, num_jobs=2, job 1 max=7 -> timeout=1 after 16 WAIT cycles, best_max=7, best_job=1, done pulses; without the macro, busy stays 1.

Source files
------------

// File: rtl/bsw_seq_ctrl.sv
// Sequencer that streams SEQ_LEN symbol pairs per job into a BSW core and tracks the best score per batch.
// Optional job watchdog in WAIT is enabled with the BSW_TIMEOUT_EN macro.
module bsw_seq_ctrl #(
  parameter int SEQ_LEN     = 256,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [3:0]                    num_jobs,
  output logic                          busy,
  output logic                          done,
  output logic                          mem_rd,
  output logic [4+$clog2(SEQ_LEN)-1:0]  mem_addr,
  input  logic [1:0]                    mem_s,
  input  logic [1:0]                    mem_t,
  output logic                          core_rst,
  output logic                          core_valid,
  output logic [1:0]                    core_s,
  output logic [1:0]                    core_t,
  input  logic                          core_finish,
  input  logic [11:0]                   core_max,
  output logic [11:0]                   best_max,
  output logic [3:0]                    best_job,
  output logic                          timeout
);

  localparam int SW = $clog2(SEQ_LEN);

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    STREAM,
    DRAIN,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    njobs_q, njobs_d;
  logic [3:0]    job_q, job_d;
  logic [SW-1:0] sym_q, sym_d;
  logic          crst_q, crst_d;
  logic          valid_q, valid_d;
  logic [11:0]   best_max_q, best_max_d;
  logic [3:0]    best_job_q, best_job_d;
  logic          job_done;

`ifdef BSW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d    = state_q;
    njobs_d    = njobs_q;
    job_d      = job_q;
    sym_d      = '0;
    crst_d     = 1'b0;
    valid_d    = (state_q == STREAM);
    best_max_d = best_max_q;
    best_job_d = best_job_q;
    job_done   = 1'b0;
`ifdef BSW_TIMEOUT_EN
    tmo_cnt_d  = '0;
    timeout_d  = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          njobs_d    = (num_jobs == 4'd0) ? 4'd1 : num_jobs;
          job_d      = 4'd0;
          best_max_d = 12'd0;
          best_job_d = 4'd0;
`ifdef BSW_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
          state_d    = CRST;
        end
      end
      CRST: begin
        crst_d = 1'b1;
        if (crst_q) begin
          crst_d  = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        sym_d = sym_q + 1'b1;
        if (sym_q == SW'(SEQ_LEN - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Strict compare so an earlier job keeps the lead on ties
        if (core_finish) begin
          if (core_max > best_max_q) begin
            best_max_d = core_max;
            best_job_d = job_q;
          end
          job_done = 1'b1;
`ifdef BSW_TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          job_done  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (job_done) begin
      if (job_q == njobs_q - 4'd1) begin
        state_d = DONE;
      end else begin
        job_d   = job_q + 4'd1;
        state_d = CRST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      njobs_q    <= 4'd0;
      job_q      <= 4'd0;
      sym_q      <= '0;
      crst_q     <= 1'b0;
      valid_q    <= 1'b0;
      best_max_q <= 12'd0;
      best_job_q <= 4'd0;
`ifdef BSW_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      njobs_q    <= njobs_d;
      job_q      <= job_d;
      sym_q      <= sym_d;
      crst_q     <= crst_d;
      valid_q    <= valid_d;
      best_max_q <= best_max_d;
      best_job_q <= best_job_d;
`ifdef BSW_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_rd     = (state_q == STREAM);
  assign core_rst   = (state_q == CRST);
  assign core_valid = valid_q;
  assign mem_addr   = {job_q, sym_q};
  assign core_s     = mem_s;
  assign core_t     = mem_t;
  assign best_max   = best_max_q;
  assign best_job   = best_job_q;

`ifdef BSW_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
